// File: rtl/xup_deser_pkg.sv
// Shared definitions for the XUP_LIB serial-to-parallel receiver.
//   state_t : receiver FSM encoding (COLLECT = 1'b0, STALL = 1'b1)
//   clog2   : ceiling log2, used to size the bit counter
package xup_deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xup_shiftreg_sipo.sv
// WIDTH-bit serial-in / parallel-out shift register with enable.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low clear
//   en       : shift din in on this edge
//   din      : serial input bit
//   q        : registered contents
//   shifted  : contents as they would be after shifting din in (combinational);
//              lets the owner capture a completed word on the same edge as its last bit
// MSB_FIRST=0 shifts right (new bit enters at WIDTH-1), MSB_FIRST=1 shifts left
// (new bit enters at 0).
module xup_shiftreg_sipo
  import xup_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] shifted
);

  generate
    if (MSB_FIRST) begin : g_left
      assign shifted = {q[WIDTH-2:0], din};
    end else begin : g_right
      assign shifted = {din, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/xup_deser4.sv
// Serial-to-parallel receiver: collects WIDTH bits over a valid/ready serial
// input and presents each completed word on a registered valid/ready output.
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset
//   sin        : serial data bit
//   sin_valid  : sin is valid
//   sin_ready  : bit accepted this cycle (registered, no path from dout_ready)
//   dout       : assembled word
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer takes dout
//   busy       : partial word held, or stalled with a second word waiting
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accepting bits; completed words go straight to dout if free
// STALL   | dout full and a completed word waits in the shift register
module xup_deser4
  import xup_deser_pkg::*;
#(
  parameter int DELAY     = 3,
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  // DELAY only matters to back-annotated simulation flows; RTL has no use for it.
  localparam int DELAY_NS_unused = DELAY;

  localparam int                CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr_q, sr_shifted, dout_nx;
  logic             dout_valid_nx;
  logic             accept, last_bit;

  assign accept   = sin_valid && sin_ready;
  assign last_bit = accept && (cnt == CNT_LAST);
  assign busy     = (cnt != '0) || (state == STALL);

  xup_shiftreg_sipo #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept),
    .din     (sin),
    .q       (sr_q),
    .shifted (sr_shifted)
  );

  always_comb begin
    state_nx      = state;
    dout_nx       = dout;
    dout_valid_nx = dout_valid;
    case (state)
      COLLECT: begin
        if (dout_valid && dout_ready) dout_valid_nx = 1'b0;
        if (last_bit) begin
          // Slot counts as free when the current word leaves on this same edge.
          if (!dout_valid || dout_ready) begin
            dout_nx       = sr_shifted;
            dout_valid_nx = 1'b1;
          end else begin
            state_nx = STALL;
          end
        end
      end
      STALL: begin
        // Old word leaves and the held word replaces it: dout_valid stays high.
        if (dout_ready) begin
          dout_nx  = sr_q;
          state_nx = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= COLLECT;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sin_ready  <= 1'b0;
    end else begin
      state      <= state_nx;
      dout       <= dout_nx;
      dout_valid <= dout_valid_nx;
      sin_ready  <= (state_nx == COLLECT);
      if (accept) cnt <= last_bit ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xup_deser4.sv
module tb_xup_deser4;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n, sin, sin_valid, dout_ready;
  logic sr_l, dv_l, busy_l, sr_m, dv_m, busy_m;
  logic [W-1:0] dout_l, dout_m;

  always #5 clk = ~clk;

  xup_deser4 #(.DELAY(3), .WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(sr_l), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .busy(busy_l)
  );

  xup_deser4 #(.DELAY(3), .WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(sr_m), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(dout_ready), .busy(busy_m)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] y;
    for (int i = 0; i < W; i++) y[i] = x[W-1-i];
    return y;
  endfunction

  // Transaction-level reference: bits received so far in the current word,
  // and completed words not yet taken by the consumer (LSB-first value).
  bit           q_bits[$];
  logic [W-1:0] q_words[$];
  bit           m_live = 1'b0;

  task automatic tick(input bit v, input bit s, input bit r, input bit rst);
    bit acc, con;
    logic [W-1:0] w;
    sin_valid  = v;
    sin        = s;
    dout_ready = r;
    reset_n    = rst;
    con = (q_words.size() > 0) && r;
    acc = v && m_live && (q_words.size() < 2);
    @(posedge clk);
    #1;
    if (!rst) begin
      q_bits.delete();
      q_words.delete();
      m_live = 1'b0;
    end else begin
      if (con) q_words.delete(0);
      if (acc) begin
        q_bits.push_back(s);
        if (q_bits.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = q_bits[i];
          q_words.push_back(w);
          q_bits.delete();
        end
      end
      m_live = 1'b1;
    end
  endtask

  task automatic check_model(input int cyc);
    logic e_rdy, e_dv, e_busy;
    e_rdy  = m_live && (q_words.size() < 2);
    e_dv   = (q_words.size() > 0);
    e_busy = (q_bits.size() != 0) || (q_words.size() == 2);
    chk($sformatf("rnd%0d_rdy_lsb", cyc), sr_l, e_rdy);
    chk($sformatf("rnd%0d_rdy_msb", cyc), sr_m, e_rdy);
    chk($sformatf("rnd%0d_dv_lsb", cyc), dv_l, e_dv);
    chk($sformatf("rnd%0d_dv_msb", cyc), dv_m, e_dv);
    chk($sformatf("rnd%0d_busy", cyc), busy_l, e_busy);
    chk($sformatf("rnd%0d_busy_msb", cyc), busy_m, e_busy);
    if (e_dv) begin
      chk($sformatf("rnd%0d_dout_lsb", cyc), dout_l, q_words[0]);
      chk($sformatf("rnd%0d_dout_msb", cyc), dout_m, rev(q_words[0]));
    end
  endtask

  typedef struct {
    logic       rst, v, s, r;
    logic       e_rdy, e_dv, e_busy;
    logic [3:0] e_dl, e_dm;
  } vec_t;

  function automatic vec_t mk(input logic rst, v, s, r, e_rdy, e_dv, e_busy,
                              input logic [3:0] e_dl, e_dm);
    vec_t t;
    t.rst = rst; t.v = v; t.s = s; t.r = r;
    t.e_rdy = e_rdy; t.e_dv = e_dv; t.e_busy = e_busy;
    t.e_dl = e_dl; t.e_dm = e_dm;
    return t;
  endfunction

  vec_t tbl[19];
  logic [3:0] sw[4];

  initial begin
    int pulses;
    logic [3:0] wa, wb;
    logic b;

    // rst v s r | rdy dv busy | dout_lsb dout_msb
    tbl[0]  = mk(0, 1, 1, 1, 0, 0, 0, 4'h0, 4'h0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 4'h0, 4'h0);
    tbl[2]  = mk(0, 1, 1, 1, 0, 0, 0, 4'h0, 4'h0);
    tbl[3]  = mk(1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0);
    tbl[4]  = mk(1, 1, 1, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[5]  = mk(1, 1, 0, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[6]  = mk(1, 1, 1, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[7]  = mk(1, 1, 1, 1, 1, 1, 0, 4'hD, 4'hB);
    tbl[8]  = mk(1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0);
    tbl[9]  = mk(1, 1, 0, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[10] = mk(1, 0, 0, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[11] = mk(1, 0, 0, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, 4'h0, 4'h0);
    tbl[13] = mk(1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0);
    tbl[14] = mk(1, 1, 1, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[15] = mk(1, 1, 1, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[16] = mk(1, 1, 1, 1, 1, 0, 1, 4'h0, 4'h0);
    tbl[17] = mk(1, 1, 1, 1, 1, 1, 0, 4'hF, 4'hF);
    tbl[18] = mk(1, 0, 0, 1, 1, 0, 0, 4'h0, 4'h0);

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].v, tbl[i].s, tbl[i].r, tbl[i].rst);
      chk($sformatf("vec%0d_rdy", i), sr_l, tbl[i].e_rdy);
      chk($sformatf("vec%0d_rdy_msb", i), sr_m, tbl[i].e_rdy);
      chk($sformatf("vec%0d_dv", i), dv_l, tbl[i].e_dv);
      chk($sformatf("vec%0d_dv_msb", i), dv_m, tbl[i].e_dv);
      chk($sformatf("vec%0d_busy", i), busy_l, tbl[i].e_busy);
      if (tbl[i].e_dv || !tbl[i].rst) begin
        chk($sformatf("vec%0d_dout_lsb", i), dout_l, tbl[i].e_dl);
        chk($sformatf("vec%0d_dout_msb", i), dout_m, tbl[i].e_dm);
      end
    end

    // Backpressure: words A then 5 with the consumer stalled.
    wa = 4'hA;
    wb = 4'h5;
    for (int i = 0; i < 4; i++) tick(1, wa[i], 0, 1);
    chk("bp_first_dv", dv_l, 1);
    chk("bp_first_dout", dout_l, 4'hA);
    chk("bp_first_dout_msb", dout_m, 4'h5);
    for (int i = 0; i < 4; i++) tick(1, wb[i], 0, 1);
    chk("bp_stall_rdy", sr_l, 0);
    chk("bp_stall_busy", busy_l, 1);
    chk("bp_stall_dout", dout_l, 4'hA);
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 0, 1);
      chk($sformatf("bp_hold%0d_dout", i), dout_l, 4'hA);
      chk($sformatf("bp_hold%0d_rdy", i), sr_l, 0);
      chk($sformatf("bp_hold%0d_dv", i), dv_l, 1);
    end
    tick(0, 0, 1, 1);
    chk("bp_release_dout", dout_l, 4'h5);
    chk("bp_release_dout_msb", dout_m, 4'hA);
    chk("bp_release_dv", dv_l, 1);
    chk("bp_release_rdy", sr_l, 1);
    chk("bp_release_busy", busy_l, 0);
    tick(0, 0, 1, 1);
    chk("bp_drain_dv", dv_l, 0);

    // Last bit of a new word lands on the edge that consumes the old one.
    wa = 4'h9;
    wb = 4'h6;
    for (int i = 0; i < 4; i++) tick(1, wa[i], 0, 1);
    for (int i = 0; i < 3; i++) tick(1, wb[i], 0, 1);
    tick(1, wb[3], 1, 1);
    chk("simul_dv", dv_l, 1);
    chk("simul_dout", dout_l, 4'h6);
    chk("simul_rdy", sr_l, 1);
    chk("simul_busy", busy_l, 0);
    tick(0, 0, 1, 1);
    chk("simul_drain_dv", dv_l, 0);

    // Streaming at one bit per cycle with the consumer always ready.
    sw[0] = 4'h3; sw[1] = 4'hC; sw[2] = 4'h9; sw[3] = 4'h6;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      wa = sw[k/4];
      b  = wa[k%4];
      tick(1, b, 1, 1);
      chk($sformatf("stream%0d_dv", k), dv_l, (k % 4) == 3);
      chk($sformatf("stream%0d_rdy", k), sr_l, 1);
      if (dv_l === 1'b1) pulses++;
      if ((k % 4) == 3) begin
        chk($sformatf("stream%0d_dout", k), dout_l, sw[k/4]);
        chk($sformatf("stream%0d_dout_msb", k), dout_m, rev(sw[k/4]));
      end
    end
    chk("stream_pulses", pulses, 4);
    tick(0, 0, 1, 1);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom % 10) < 7, $urandom % 2, $urandom % 2, $urandom_range(0, 63) != 0);
      check_model(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
